// File: rtl/m_cycle_sequencer.sv
// ============================================================================
// Module  : m_cycle_sequencer
// Purpose : One-hot T-state / M-cycle timing generator with HALT, wait-stall
//           and runaway-instruction (count overflow) detection.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module m_cycle_sequencer #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Enable,
  input  logic                   i_IR_Fetch,
  input  logic                   i_Halt,
  input  logic                   i_Wake,
  input  logic                   i_Wait,
  output logic [3:0]             o_Cycle_Step,
  output logic [COUNT_WIDTH-1:0] o_Cycle_Count,
  output logic                   o_Fetch_Cycle,
  output logic                   o_Halted,
  output logic                   o_Overflow
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [3:0]             STEP_T1     = 4'b0001;
  localparam logic [3:0]             STEP_NONE   = 4'b0000;
  localparam logic [1:0]             PH_LAST     = 2'd3;
  localparam logic [1:0]             PH_WAIT     = 2'd1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_FIRST = COUNT_WIDTH'(1);

  state_t     state;
  logic [1:0] ph;

  logic boundary;
  logic stall;
  logic count_at_msb;

  assign boundary     = (ph == PH_LAST);
  assign stall        = (ph == PH_WAIT) && i_Wait;
  assign count_at_msb = o_Cycle_Count[COUNT_WIDTH-1];

  // Every output is a register; nothing decodes combinationally from inputs.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state         <= ST_RUN;
      ph            <= 2'd0;
      o_Cycle_Step  <= STEP_T1;
      o_Cycle_Count <= COUNT_FIRST;
      o_Fetch_Cycle <= 1'b1;
      o_Halted      <= 1'b0;
      o_Overflow    <= 1'b0;
    end else if (i_Enable) begin
      case (state)
        ST_RUN: begin
          if (boundary) begin
            ph           <= 2'd0;
            o_Cycle_Step <= STEP_T1;
            if (i_IR_Fetch) begin
              o_Cycle_Count <= COUNT_FIRST;
              if (i_Halt && !i_Wake) begin
                state         <= ST_HALT;
                o_Cycle_Step  <= STEP_NONE;
                o_Fetch_Cycle <= 1'b0;
                o_Halted      <= 1'b1;
              end else begin
                o_Fetch_Cycle <= 1'b1;
              end
            end else if (count_at_msb) begin
              // Instruction never requested a fetch: restart and flag it.
              o_Cycle_Count <= COUNT_FIRST;
              o_Fetch_Cycle <= 1'b1;
              o_Overflow    <= 1'b1;
            end else begin
              o_Cycle_Count <= o_Cycle_Count << 1;
              o_Fetch_Cycle <= 1'b0;
            end
          end else if (!stall) begin
            ph           <= ph + 2'd1;
            o_Cycle_Step <= STEP_T1 << (ph + 2'd1);
          end
        end

        ST_HALT: begin
          if (boundary && i_Wake) begin
            state         <= ST_RUN;
            ph            <= 2'd0;
            o_Cycle_Step  <= STEP_T1;
            o_Cycle_Count <= COUNT_FIRST;
            o_Fetch_Cycle <= 1'b1;
            o_Halted      <= 1'b0;
          end else begin
            ph <= ph + 2'd1;
          end
        end

        default: begin
          state <= ST_RUN;
          ph    <= 2'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/m_cycle_sequencer.md
# m_cycle_sequencer

Generates the one-hot T-state (`o_Cycle_Step`) and one-hot M-cycle (`o_Cycle_Count`) timing vectors that every instruction microcode block (CALL, JP, LD, ...) decodes. Sits in the ControlUnit between the clock-enable source and the microcode decoders. Restarts the M-cycle count whenever the active microcode requests an instruction fetch. Also handles HALT entry/wake-up, memory wait-stalls and runaway-instruction detection.

## Interface
- `COUNT_WIDTH`, default 8: width of the one-hot M-cycle vector.
- `i_Clk` in 1: system clock; all state updates on rising edge.
- `i_Reset` in 1: asynchronous, active-high reset.
- `i_Enable` in 1: T-state advance enable; when low, all state holds.
- `i_IR_Fetch` in 1: OR of all microcode `o_IR_Fetch`; sampled at M-cycle boundary.
- `i_Halt` in 1: HALT requested by the current instruction; sampled at M-cycle boundary.
- `i_Wake` in 1: interrupt pending (IE & IF nonzero); exits HALT.
- `i_Wait` in 1: memory not ready; stalls T-state 1.
- `o_Cycle_Step` out 4: one-hot T-state; 4'b0000 while halted.
- `o_Cycle_Count` out COUNT_WIDTH: one-hot M-cycle index within the instruction.
- `o_Fetch_Cycle` out 1: `o_Cycle_Count[0]` & running (opcode fetch M-cycle).
- `o_Halted` out 1: high in HALT state.
- `o_Overflow` out 1: sticky error; count ran past its MSB without an IR fetch.

## Operation
- Two states: RUN, HALT. Internal 2-bit phase counter `ph` runs in both states.
- Reset (async): state=RUN, ph=0, `o_Cycle_Step`=4'b0001, `o_Cycle_Count`=1 (bit 0), `o_Fetch_Cycle`=1, `o_Halted`=0, `o_Overflow`=0.
- RUN:
  - `o_Cycle_Step` = one-hot of ph.
  - On `i_Enable`, ph increments modulo 4.
  - Exception: when ph==1 and `i_Wait`=1, ph holds. `i_Wait` is ignored at every other ph.
- M-cycle boundary = `i_Enable` & ph==3 in RUN. At the boundary:
  - `i_IR_Fetch`=1: Count <= bit 0.
  - `i_IR_Fetch`=1 & `i_Halt`=1 & `i_Wake`=0: additionally state <= HALT.
  - `i_IR_Fetch`=0 and Count[COUNT_WIDTH-1]=0: Count shifts left one.
  - `i_IR_Fetch`=0 and Count[COUNT_WIDTH-1]=1: Count <= bit 0 and `o_Overflow` <= 1. `o_Overflow` is cleared only by reset.
- `i_Halt` without `i_IR_Fetch` at a boundary is ignored.
- `i_Halt` and `i_Wake` both high at the same boundary: remain in RUN (HALT skipped).
- HALT:
  - `o_Cycle_Step`=0, so no microcode acts.
  - Count holds bit 0; `o_Fetch_Cycle`=0; `o_Halted`=1.
  - ph keeps advancing on `i_Enable`; `i_Wait` is ignored.
  - On `i_Enable` & ph==3 & `i_Wake`: state <= RUN, ph <= 0. Next `o_Cycle_Step`=4'b0001, Count=bit 0.
- Count is always exactly one-hot; Step is one-hot in RUN and zero in HALT.

## Timing
- All outputs are registered or decoded from registers only. No combinational path from any input to any output.
- With `i_Enable` high every clock: one M-cycle = 4 clocks. Each `i_Wait` clock at ph==1 adds one clock.
- `i_IR_Fetch`/`i_Halt` are sampled only on the boundary clock. The new Count is visible the clock after the boundary, together with Step=4'b0001.
- HALT exit latency: 1 to 4 enabled clocks after `i_Wake` rises, aligned to a phase wrap.
- Reset mid-instruction or mid-HALT: immediate return to reset values, asynchronously.

## Test plan
- Reset release, `i_Enable`=1, `i_IR_Fetch` high at Count bit 5 (CALL taken) -> Step cycles 0001,0010,0100,1000. Count walks 1,2,4,8,16,32, then returns to 1; 24 clocks total.
- `i_Enable` toggling 1,0,1,0 -> Step advances only on enabled clocks, with identical sequence and no skipped states.
- `i_Wait` high 3 clocks while Step=0010 -> Step holds 0010 for 4 clocks, then 0100. `i_Wait` asserted at Step=0100 -> no effect.
- `i_Halt`+`i_IR_Fetch` at boundary -> `o_Halted`=1, Step=0000. Raise `i_Wake` 6 clocks later -> RUN resumes at next ph wrap with Step=0001, Count=1. Repeat with `i_Wake` already high at the boundary -> HALT never entered.
- `i_IR_Fetch` held 0 -> after 8 M-cycles Count wraps to 1 and `o_Overflow`=1. `o_Overflow` stays 1 through later fetches and clears only on `i_Reset`.
- Assert `i_Reset` asynchronously mid-cycle at Count=4, Step=0100 -> outputs go to reset values before the next clock edge.
